// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and lock/position status of the VGA sync monitor.
// The source drives hs/vs through master; the monitor owns every status signal through slave.
interface vga_sync_monitor_if;
  logic        hs;
  logic        vs;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] h_period;
  logic [10:0] v_period;
  logic        locked;
  logic        frame_start;
  logic        timing_err;

  modport master (
    output hs, vs,
    input  x, y, h_period, v_period, locked, frame_start, timing_err
  );

  modport slave (
    input  hs, vs,
    output x, y, h_period, v_period, locked, frame_start, timing_err
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Sync-only VGA receiver: measures hs/vs timing, locks to the 800x600@72 mode and rebuilds (x, y).
// Build macro VGA_MON_INSYNC_EN adds two-flop synchronizers on hs/vs for asynchronous sources.
module vga_sync_monitor #(
  parameter int H_TOTAL      = 1040,
  parameter int V_TOTAL      = 666,
  parameter int H_SYNC       = 120,
  parameter int V_SYNC       = 6,
  parameter int H_SYNC_START = 856,
  parameter int V_SYNC_START = 637,
  parameter int LOCK_FRAMES  = 2
) (
  input logic               clk,
  input logic               rst,
  vga_sync_monitor_if.slave bus
);
  // state   | meaning
  // SEARCH  | waiting for a vs fall preceded by at least one hs fall
  // MEASURE | counting consecutive clean frames toward lock
  // LOCKED  | timing matches the mode, x/y are valid
  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [10:0] CNT_MAX   = 11'h7ff;
  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [2:0]  LOCK_C    = 3'(LOCK_FRAMES);

  state_t      state, state_nxt;
  logic        hs_in, vs_in, hs_d, vs_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] hcnt, hcnt_inc, hcnt_nxt, hlow, hlow_nxt;
  logic [10:0] vcnt, vcnt_inc, vcnt_nxt, vlow, vlow_nxt;
  logic [10:0] h_period_r, v_period_r, x_r, y_r, x_calc, y_calc;
  logic        bad, vsync_ok, hs_seen;
  logic        line_viol, frame_viol, tmo, err_nxt;
  logic        frame_start_r, timing_err_r;
  logic [2:0]  good_cnt, good_nxt;

`ifdef VGA_MON_INSYNC_EN
  localparam int SYNC_LAT = 2;
  logic [1:0] hs_sync, vs_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sync <= 2'b11;
      vs_sync <= 2'b11;
    end else begin
      hs_sync <= {hs_sync[0], bus.hs};
      vs_sync <= {vs_sync[0], bus.vs};
    end
  end

  assign hs_in = hs_sync[1];
  assign vs_in = vs_sync[1];
`else
  localparam int SYNC_LAT = 0;
  assign hs_in = bus.hs;
  assign vs_in = bus.vs;
`endif

  // Synchronizer delay is folded into the column offset so x keeps the generator's meaning.
  localparam int X_OFS = H_SYNC_START + SYNC_LAT;

  assign hs_fall = hs_d & ~hs_in;
  assign hs_rise = ~hs_d & hs_in;
  assign vs_fall = vs_d & ~vs_in;
  assign vs_rise = ~vs_d & vs_in;

  assign hcnt_inc = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 11'd1;
  assign hcnt_nxt = hs_fall ? 11'd0 : hcnt_inc;
  assign hlow_nxt = hs_fall ? 11'd1 :
                    (!hs_in && hlow != CNT_MAX) ? hlow + 11'd1 : hlow;
  // A line ending on the vs fall clock still belongs to the frame that is closing.
  assign vcnt_inc = (hs_fall && vcnt != CNT_MAX) ? vcnt + 11'd1 : vcnt;
  assign vcnt_nxt = vs_fall ? 11'd0 : vcnt_inc;
  assign vlow_nxt = vs_fall ? {10'd0, hs_fall} :
                    (!vs_in && hs_fall && vlow != CNT_MAX) ? vlow + 11'd1 : vlow;

  assign line_viol  = (hs_fall && hcnt_inc != H_TOTAL_C) || (hs_rise && hlow != H_SYNC_C);
  assign frame_viol = vs_fall && (bad || vcnt_inc != V_TOTAL_C || !vsync_ok);
  assign tmo        = (hcnt == CNT_MAX - 11'd1) && !hs_fall;

  assign x_calc = 11'((int'(hcnt_nxt) + X_OFS) % H_TOTAL);
  assign y_calc = 11'((int'(vcnt_nxt) + V_SYNC_START) % V_TOTAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    if (tmo) begin
      state_nxt = SEARCH;
      good_nxt  = 3'd0;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_fall && (hs_seen || hs_fall)) begin
            state_nxt = MEASURE;
            good_nxt  = 3'd0;
          end
        end
        MEASURE: begin
          if (line_viol || frame_viol) begin
            err_nxt  = 1'b1;
            good_nxt = 3'd0;
          end else if (vs_fall) begin
            good_nxt = good_cnt + 3'd1;
            if (good_cnt + 3'd1 == LOCK_C) state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (line_viol || frame_viol) begin
            err_nxt   = 1'b1;
            good_nxt  = 3'd0;
            state_nxt = MEASURE;
          end
        end
        default: begin
          state_nxt = SEARCH;
          good_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d          <= 1'b1;
      vs_d          <= 1'b1;
      hcnt          <= 11'd0;
      hlow          <= 11'd0;
      vcnt          <= 11'd0;
      vlow          <= 11'd0;
      h_period_r    <= 11'd0;
      v_period_r    <= 11'd0;
      bad           <= 1'b0;
      vsync_ok      <= 1'b0;
      hs_seen       <= 1'b0;
      good_cnt      <= 3'd0;
      frame_start_r <= 1'b0;
      timing_err_r  <= 1'b0;
      x_r           <= 11'd0;
      y_r           <= 11'd0;
    end else begin
      hs_d          <= hs_in;
      vs_d          <= vs_in;
      hcnt          <= hcnt_nxt;
      hlow          <= hlow_nxt;
      vcnt          <= vcnt_nxt;
      vlow          <= vlow_nxt;
      if (hs_fall) h_period_r <= hcnt_inc;
      if (vs_fall) v_period_r <= vcnt_inc;
      if (vs_rise) vsync_ok   <= (vlow == V_SYNC_C);
      bad           <= vs_fall ? 1'b0 : (bad | line_viol);
      hs_seen       <= tmo ? 1'b0 : (hs_seen | hs_fall);
      good_cnt      <= good_nxt;
      frame_start_r <= vs_fall;
      timing_err_r  <= err_nxt;
      // Gated on the next state so x/y become valid together with locked.
      x_r           <= (state_nxt == LOCKED) ? x_calc : 11'd0;
      y_r           <= (state_nxt == LOCKED) ? y_calc : 11'd0;
    end
  end

  assign bus.x           = x_r;
  assign bus.y           = y_r;
  assign bus.h_period    = h_period_r;
  assign bus.v_period    = v_period_r;
  assign bus.locked      = (state == LOCKED);
  assign bus.frame_start = frame_start_r;
  assign bus.timing_err  = timing_err_r;
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: watches hs/vs (active-low sync pulses), measures line and frame timing, checks it against the 800x600@72 mode, and reports lock.
- Once locked, reconstructs the pixel position (x, y) in the generator's coordinate space.
- Used for loopback self-test of the video path and by downstream capture logic that has only the sync signals.

Parameters:
- H_TOTAL, 1040, expected clocks per line.
- V_TOTAL, 666, expected lines per frame.
- H_SYNC, 120, expected hs low width in clocks.
- V_SYNC, 6, expected vs low width in lines (hs falling edges while vs low).
- H_SYNC_START, 856, x coordinate assigned to the clock of hs falling edge detection.
- V_SYNC_START, 637, y coordinate assigned to the line on which vs falls.
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..7).

Ports:
- clk  input  1  pixel clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- hs  input  1  horizontal sync, active low, synchronous to clk.
- vs  input  1  vertical sync, active low, synchronous to clk.
- x  output  11  reconstructed column, 0..H_TOTAL-1; 0 when not locked.
- y  output  11  reconstructed line, 0..V_TOTAL-1; 0 when not locked.
- h_period  output  11  last measured line length in clocks.
- v_period  output  11  last measured frame length in lines.
- locked  output  1  high in LOCKED state.
- frame_start  output  1  one-cycle pulse on every vs falling edge.
- timing_err  output  1  one-cycle pulse on any detected violation.

Behaviour:
- Reset (async, rst=1): all outputs 0; internal hs_d/vs_d = 1; state SEARCH; all counters 0.
- Edge detect: hs_fall = hs_d & ~hs; hs_rise = ~hs_d & hs; same for vs. hs_d/vs_d are registered copies of the inputs.
- hcnt: increments every clock and saturates at 2047. On hs_fall: h_period <= hcnt+1, hcnt <= 0.
- hlow: counts clocks while hs = 0. On hs_rise it is compared to H_SYNC.
- vcnt: +1 on each hs_fall. On vs_fall: v_period <= vcnt + hs_fall (same-cycle hs_fall counts in the ending frame), vcnt <= 0.
- vlow: counts hs_fall while vs = 0. On vs_rise it is compared to V_SYNC.
- Line violation: h_period != H_TOTAL at hs_fall, or hlow != H_SYNC at hs_rise. Any violation sets a sticky bad flag that is cleared at vs_fall.
- Frame violation at vs_fall: bad flag set, v_period != V_TOTAL, or last vlow != V_SYNC.
- State SEARCH:
  - Checks are ignored.
  - On vs_fall, go to MEASURE only if at least one hs_fall has been seen since reset or entry; otherwise stay.
- State MEASURE:
  - On vs_fall with no frame violation: good_cnt+1.
  - When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - On violation: pulse timing_err, good_cnt <= 0, stay in MEASURE.
- State LOCKED: any line or frame violation pulses timing_err, clears good_cnt, and drops to MEASURE. locked falls the next cycle.
- Timeout: hcnt reaching 2047 in any state pulses timing_err once and sends the state to SEARCH.
- timing_err fires at most once per clock, even with multiple simultaneous causes.
- x/y (registered, 1-cycle latency):
  - In LOCKED, x = (hcnt + H_SYNC_START) mod H_TOTAL, where hcnt is the post-update value.
  - y = (vcnt + V_SYNC_START) mod V_TOTAL.
  - Each wraps to 0 at its total.
  - Forced to 0 in other states.
- frame_start pulses on every vs_fall regardless of state.
- Mid-operation reset: immediate return to reset values; relock needs a full SEARCH/MEASURE sequence.

Optional Feature:
- Macro VGA_MON_INSYNC_EN.
- Defined: hs and vs pass through two-flop synchronizers (reset value 1) before edge detection, for sync inputs from an asynchronous source. All detection is delayed by 2 clocks. H_SYNC_START and V_SYNC_START semantics are unchanged; the offset is absorbed into the x computation.
- Undefined: inputs feed edge detection directly.

Test Plan:
- Nominal 800x600 stream from a generator model (1040x666, hs low 120, vs low 6 lines) -> locked rises 1 cycle after the 3rd vs_fall.
  - h_period = 1040, v_period = 666, timing_err never pulses.
  - x = 856 on the cycle after hs_fall.
- Locked stream; one line stretched to 1041 clocks -> timing_err pulses at that line's hs_fall, locked drops, relock after 2 good frames.
- Locked stream; hs low for 119 clocks on one line -> timing_err pulses at that hs_rise, state goes to MEASURE.
- hs held high for 2100 clocks -> a single timing_err pulse at hcnt = 2047, state SEARCH, x = y = 0.
- vs_fall in the same cycle as hs_fall -> v_period includes that line (666 for a nominal frame), vcnt restarts at 0.
- Assert rst mid-frame while locked -> all outputs 0 immediately; after release, locked returns only after 3 vs falls.
